sha_pad: RTL

Parametrised SHA message padder between the byte-stream source (file reader or bus front-end) and the SHA compression core. It accepts a message as a valid/ready stream of fixed-width beats and emits complete, padded message blocks: 0x80 terminator, zero fill and big-endian bit length. Block and length widths are parameters, so one block serves SHA-1/SHA-256 (512/64) and SHA-384/SHA-512 (1024/128).

---
 rtl/sha_pad_pkg.sv | 24 ++
 rtl/sha_pad_tail.sv | 34 +++
 rtl/sha_pad.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sha_pad_pkg.sv
// sha_pad_pkg: SHA variant block/length widths, padder FSM states and stream record types
package sha_pad_pkg;
    localparam int SHA1_BLOCK_BITS   = 512;
    localparam int SHA1_LEN_BITS     = 64;
    localparam int SHA256_BLOCK_BITS = 512;
    localparam int SHA256_LEN_BITS   = 64;
    localparam int SHA384_BLOCK_BITS = 1024;
    localparam int SHA384_LEN_BITS   = 128;
    localparam int SHA512_BLOCK_BITS = 1024;
    localparam int SHA512_LEN_BITS   = 128;
    typedef enum logic [1:0] {FILL, EMIT, FINAL} pad_state_t;
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
        logic        last;
        logic        valid;
    } sha_pad_in_type;
    typedef struct packed {
        logic [SHA256_BLOCK_BITS-1:0] block;
        logic                         first;
        logic                         last;
        logic                         valid;
    } sha_pad_out_type;
endpackage

// File: rtl/sha_pad_tail.sv
// sha_pad_tail: combinational builder of a padded block from buffer, end pointer p and bit length
// Ports: blk_in buffered message bytes; p first byte after the message; len bit length;
//        extra selects the all-zero trailing block (byte 0 = 0x80 when set_80);
//        blk_out padded block; fits is high when the length field fits after the 0x80 terminator.
module sha_pad_tail
    import sha_pad_pkg::*;
#(
    parameter int BLOCK_BITS = 512,
    parameter int LEN_BITS   = 64,
    parameter int PW         = 8
) (
    input  logic [BLOCK_BITS-1:0] blk_in,
    input  logic [PW-1:0]         p,
    input  logic [LEN_BITS-1:0]   len,
    input  logic                  extra,
    input  logic                  set_80,
    output logic [BLOCK_BITS-1:0] blk_out,
    output logic                  fits
);
    localparam int BB = BLOCK_BITS / 8;
    localparam int LB = LEN_BITS / 8;
    logic [BLOCK_BITS-1:0] pad;
    for (genvar j = 0; j < BB; j++) begin : g_byte
        assign pad[BLOCK_BITS-1-8*j -: 8] = extra ? 8'h00 :
                                            j < int'(p) ? blk_in[BLOCK_BITS-1-8*j -: 8] :
                                            j == int'(p) ? 8'h80 : 8'h00;
    end
    always_comb begin
        fits = int'(p) <= BB - LB - 1;
        blk_out = pad;
        if (extra && set_80) blk_out[BLOCK_BITS-1 -: 8] = 8'h80;
        if (extra || fits) blk_out[LEN_BITS-1:0] = len;
    end
endmodule

// File: rtl/sha_pad.sv
// sha_pad: SHA message padder, valid/ready byte beats in, padded BLOCK_BITS blocks out
// Ports: clk, rst (synchronous, active-high);
//        in_valid/in_ready/in_data/in_nbytes/in_last: message beats, byte 0 in MSBs;
//        out_valid/out_ready/out_block/out_first/out_last: padded blocks, held until accepted;
//        err: sticky beat-size / length-wrap error, present only when SHA_PAD_ERR_EN is defined.
module sha_pad
    import sha_pad_pkg::*;
#(
    parameter int BLOCK_BITS = 512,
    parameter int LEN_BITS   = 64,
    parameter int IN_BYTES   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*IN_BYTES-1:0]       in_data,
    input  logic [$clog2(IN_BYTES):0]   in_nbytes,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BLOCK_BITS-1:0]       out_block,
    output logic                        out_first,
    output logic                        out_last
`ifdef SHA_PAD_ERR_EN
    ,
    output logic                        err
`endif
);
    localparam int BB = BLOCK_BITS / 8;
    localparam int PW = $clog2(BB) + 2;
    pad_state_t state, ret;
    logic [BLOCK_BITS-1:0] blk_q, wbuf, tail;
    logic [PW-1:0] ptr, np;
    logic [LEN_BITS-1:0] len, nl;
    logic first_pend, extra_80, fits, fire;
    assign in_ready  = state == FILL;
    assign out_valid = state == EMIT;
    assign out_block = out_valid ? blk_q : '0;
    assign fire      = in_valid && in_ready;
    assign np        = ptr + PW'(in_nbytes);
    assign nl        = len + LEN_BITS'({in_nbytes, 3'b000});
    // Beats arrive whole until the last one, so ptr is always beat-aligned when a beat lands.
    for (genvar s = 0; s < BB / IN_BYTES; s++) begin : g_slot
        for (genvar k = 0; k < IN_BYTES; k++) begin : g_lane
            assign wbuf[BLOCK_BITS-1-8*(s*IN_BYTES+k) -: 8] =
                (int'(ptr) == s * IN_BYTES && k < int'(in_nbytes)) ?
                in_data[8*IN_BYTES-1-8*k -: 8] : blk_q[BLOCK_BITS-1-8*(s*IN_BYTES+k) -: 8];
        end
    end
    sha_pad_tail #(.BLOCK_BITS(BLOCK_BITS), .LEN_BITS(LEN_BITS), .PW(PW)) u_tail (
        .blk_in  (wbuf),
        .p       (np),
        .len     (state == FINAL ? len : nl),
        .extra   (state == FINAL),
        .set_80  (extra_80),
        .blk_out (tail),
        .fits    (fits)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            ret        <= FILL;
            blk_q      <= '0;
            ptr        <= '0;
            len        <= '0;
            first_pend <= 1'b1;
            extra_80   <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                FILL: if (fire) begin
                    len <= nl;
                    ptr <= np;
                    ret <= FILL;
                    if (in_last) begin
                        blk_q     <= tail;
                        state     <= EMIT;
                        out_first <= first_pend;
                        out_last  <= fits;
                        ret       <= fits ? FILL : FINAL;
                        extra_80  <= int'(np) == BB;
                    end else begin
                        blk_q <= wbuf;
                        if (int'(np) >= BB) begin
                            state     <= EMIT;
                            out_first <= first_pend;
                            out_last  <= 1'b0;
                        end
                    end
                end
                FINAL: begin
                    blk_q     <= tail;
                    state     <= EMIT;
                    out_first <= first_pend;
                    out_last  <= 1'b1;
                    ret       <= FILL;
                end
                EMIT: if (out_ready) begin
                    ptr        <= '0;
                    state      <= ret;
                    first_pend <= out_last;
                    out_first  <= 1'b0;
                    out_last   <= 1'b0;
                    if (out_last) len <= '0;
                end
                default: state <= FILL;
            endcase
        end
    end
`ifdef SHA_PAD_ERR_EN
    // nl < len only happens when the bit counter wrapped past 2^LEN_BITS.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (fire && ((!in_last && int'(in_nbytes) != IN_BYTES) ||
                          int'(in_nbytes) > IN_BYTES || nl < len)) err <= 1'b1;
    end
`endif
endmodule
